// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: default address, register depth
// and the protocol state encoding.
package i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010110;
    localparam int         NREG_DEFAULT     = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR,
        ST_ACK_PTR,
        ST_WDATA,
        ST_ACK_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
// Edge strobes are combinational from the last two stages, so the consumer acts 3 clk after the pin.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            // p0/p1: two-flop synchronizer; p2: edge-detect history
            scl_p0 <= scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign sda_s     = sda_p1;
    assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an NREG x 8-bit register file with an auto-incrementing pointer.
// Data is sampled on SCL rise; SDA drive is updated only on SCL fall (plus STOP/reset release).
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         NREG     = NREG_DEFAULT,
    localparam int        PW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_valid,
    output logic [PW-1:0] wr_ptr,
    output logic [7:0]    wr_data,
    output logic          xfer_done
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    state_e                 state_q, state_d;
    logic [NREG-1:0][7:0]   regs;
    logic [7:0]             shreg, tx_q, tx_d;
    logic [3:0]             cnt;
    logic [PW-1:0]          ptr, rd_ptr;
    logic                   rack_nack, oe_d;
    logic                   byte_done, addr_match;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NREG - 1)) ? '0 : p + 1'b1;
    endfunction

    i2c_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_done  = (cnt == 4'd8);
    assign addr_match = (shreg[7:1] == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Byte-level transitions happen on the SCL fall that closes a bit slot.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR:      if (byte_done) state_d = addr_match ? ST_ACK_ADDR : ST_WAIT_STOP;
                ST_ACK_ADDR:  state_d = shreg[0] ? ST_RDATA : ST_PTR;
                ST_PTR:       if (byte_done) state_d = ST_ACK_PTR;
                ST_ACK_PTR:   state_d = ST_WDATA;
                ST_WDATA:     if (byte_done) state_d = ST_ACK_WDATA;
                ST_ACK_WDATA: state_d = ST_WDATA;
                ST_RDATA:     if (byte_done) state_d = ST_RACK;
                ST_RACK:      state_d = rack_nack ? ST_WAIT_STOP : ST_RDATA;
                default:      ;
            endcase
        end
    end

    // SDA drive for the slot that begins at this SCL fall.
    always_comb begin
        rd_ptr = (state_q == ST_RACK) ? ptr_inc(ptr) : ptr;
        tx_d   = tx_q;
        oe_d   = 1'b0;
        case (state_d)
            ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WDATA: oe_d = 1'b1;
            ST_RDATA: begin
                tx_d = (state_q == ST_RDATA) ? {tx_q[6:0], 1'b0} : regs[rd_ptr];
                oe_d = ~tx_d[7];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            xfer_done <= 1'b0;
            wr_ptr    <= '0;
            wr_data   <= '0;
            ptr       <= '0;
            regs      <= '0;
            shreg     <= '0;
            tx_q      <= '0;
            cnt       <= '0;
            rack_nack <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            xfer_done <= 1'b0;
            if (stop_det) begin
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                xfer_done <= busy;
            end else if (start_det) begin
                cnt <= '0;
            end else if (scl_rise) begin
                if (state_q inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA}) begin
                    shreg <= {shreg[6:0], sda_s};
                    cnt   <= cnt + 4'd1;
                end
                // The write commits on the 8th rise so an aborted byte never lands.
                if (state_q == ST_WDATA && cnt == 4'd7) begin
                    regs[ptr] <= {shreg[6:0], sda_s};
                    wr_valid  <= 1'b1;
                    wr_ptr    <= ptr;
                    wr_data   <= {shreg[6:0], sda_s};
                    ptr       <= ptr_inc(ptr);
                end
                if (state_q == ST_RACK) rack_nack <= sda_s;
            end else if (scl_fall) begin
                sda_oe <= oe_d;
                tx_q   <= tx_d;
                if (state_d != state_q) cnt <= '0;
                if (state_q == ST_ADDR && byte_done) busy <= addr_match;
                if (state_q == ST_PTR && byte_done) ptr <= shreg[PW-1:0];
                if (state_q == ST_RACK && !rack_nack) ptr <= ptr_inc(ptr);
            end
        end
    end

endmodule
